pll_rst_seq: RTL and testbench

PLL_RST_SEQ -- requirements
Module: pll_rst_seq

---
 rtl/pll_rst_seq.sv | 166 ++++++++++++++++
 tb/tb_pll_rst_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a synchronized lock,
// requires a stable lock window before releasing the system reset, and
// restarts the PLL on lock loss or lock timeout. Supports PLL standby.
module pll_rst_seq #(
   parameter int unsigned RST_HOLD      = 16,
   parameter int unsigned LOCK_TIMEOUT  = 50000,
   parameter int unsigned STABLE_CYCLES = 1024
) (
   input  logic       refclk,
   input  logic       reset,
   input  logic       extlock,
   input  logic       stdby_req,
   output logic       pll_reset,
   output logic       pll_stdby,
   output logic       sys_rst,
   output logic       locked,
   output logic [7:0] lock_loss_cnt,
   output logic       timeout_err
);

   // One shared counter, wide enough for the largest terminal count.
   localparam int unsigned CNT_MAX_A = (RST_HOLD > LOCK_TIMEOUT) ? RST_HOLD : LOCK_TIMEOUT;
   localparam int unsigned CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
   localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);

   typedef enum logic [2:0] {
      StPrst,
      StWait,
      StStab,
      StRun,
      StStdby
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_sync1;
   logic             r_sync2;
   logic             w_lock_s;
   logic             w_loss;
   logic             w_tmo;

   logic             r_pll_reset;
   logic             r_pll_stdby;
   logic             r_sys_rst;
   logic             r_locked;
   logic [7:0]       r_loss_cnt;
   logic             r_timeout_err;

   assign w_lock_s = r_sync2;

   // Two-flop synchronizer for the asynchronous PLL lock flag.
   always_ff @(posedge refclk) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= extlock;
         r_sync2 <= r_sync1;
      end
   end

   // Next-state, counter and event decode.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CNT_ONE;
      w_loss      = 1'b0;
      w_tmo       = 1'b0;
      unique case (r_state)
         StPrst: begin
            if (r_cnt == HOLD_LAST) begin
               w_state_nxt = StWait;
               w_cnt_nxt   = CNT_ZERO;
            end
         end
         StWait: begin
            if (w_lock_s) begin
               w_state_nxt = StStab;
               w_cnt_nxt   = CNT_ZERO;
            end else if (r_cnt == TMO_LAST) begin
               w_state_nxt = StPrst;
               w_cnt_nxt   = CNT_ZERO;
               w_tmo       = 1'b1;
            end
         end
         StStab: begin
            if (!w_lock_s) begin
               w_state_nxt = StWait;
               w_cnt_nxt   = CNT_ZERO;
            end else if (r_cnt == STAB_LAST) begin
               w_state_nxt = StRun;
               w_cnt_nxt   = CNT_ZERO;
            end
         end
         StRun: begin
            w_cnt_nxt = CNT_ZERO;
            // Lock loss wins over a simultaneous standby request.
            if (!w_lock_s) begin
               w_state_nxt = StPrst;
               w_loss      = 1'b1;
            end else if (stdby_req) begin
               w_state_nxt = StStdby;
            end
         end
         StStdby: begin
            w_cnt_nxt = CNT_ZERO;
            if (!stdby_req) begin
               w_state_nxt = StPrst;
            end
         end
         default: begin
            w_state_nxt = StPrst;
            w_cnt_nxt   = CNT_ZERO;
         end
      endcase
   end

   // State and shared counter registers.
   always_ff @(posedge refclk) begin
      if (reset) begin
         r_state <= StPrst;
         r_cnt   <= CNT_ZERO;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Registered outputs decoded from the next state so they track the state register.
   always_ff @(posedge refclk) begin
      if (reset) begin
         r_pll_reset   <= 1'b1;
         r_pll_stdby   <= 1'b0;
         r_sys_rst     <= 1'b1;
         r_locked      <= 1'b0;
         r_loss_cnt    <= 8'd0;
         r_timeout_err <= 1'b0;
      end else begin
         r_pll_reset <= (w_state_nxt == StPrst);
         r_pll_stdby <= (w_state_nxt == StStdby);
         r_sys_rst   <= (w_state_nxt != StRun);
         r_locked    <= (w_state_nxt == StRun);
         if (w_loss && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
         end
         if (w_tmo) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign pll_reset     = r_pll_reset;
   assign pll_stdby     = r_pll_stdby;
   assign sys_rst       = r_sys_rst;
   assign locked        = r_locked;
   assign lock_loss_cnt = r_loss_cnt;
   assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: expected output snapshots are queued with the cycle
// at which they must appear and compared by a monitor on the falling edge.
module tb_pll_rst_seq;

   logic       refclk;
   logic       reset;
   logic       extlock;
   logic       stdby_req;
   logic       pll_reset;
   logic       pll_stdby;
   logic       sys_rst;
   logic       locked;
   logic [7:0] lock_loss_cnt;
   logic       timeout_err;

   pll_rst_seq #(
      .RST_HOLD      (4),
      .LOCK_TIMEOUT  (20),
      .STABLE_CYCLES (8)
   ) u_dut (
      .refclk        (refclk),
      .reset         (reset),
      .extlock       (extlock),
      .stdby_req     (stdby_req),
      .pll_reset     (pll_reset),
      .pll_stdby     (pll_stdby),
      .sys_rst       (sys_rst),
      .locked        (locked),
      .lock_loss_cnt (lock_loss_cnt),
      .timeout_err   (timeout_err)
   );

   typedef struct {
      int unsigned cyc;
      string       tag;
      logic [12:0] exp;
   } sb_t;

   sb_t         sb_q[$];
   sb_t         e_mon;
   int unsigned cyc;
   int unsigned n_vec;
   int unsigned n_err;
   logic [12:0] w_obs;

   assign w_obs = {pll_reset, pll_stdby, sys_rst, locked, timeout_err, lock_loss_cnt};

   initial begin
      refclk = 1'b0;
      forever #5 refclk = ~refclk;
   end

   initial cyc = 0;
   always @(posedge refclk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Pop and compare every expectation due at this cycle.
   always @(negedge refclk) begin
      while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
         e_mon = sb_q.pop_front();
         check(e_mon.tag, 32'(w_obs), 32'(e_mon.exp));
      end
   end

   function automatic logic [12:0] mk(input bit pr, input bit sb, input bit sr, input bit lk,
                                      input bit te, input int unsigned llc);
      return {pr, sb, sr, lk, te, 8'(llc)};
   endfunction

   function automatic logic [12:0] v_prst(input bit te, input int unsigned llc);
      return mk(1'b1, 1'b0, 1'b1, 1'b0, te, llc);
   endfunction
   // WAIT and STAB drive identical outputs.
   function automatic logic [12:0] v_wait(input bit te, input int unsigned llc);
      return mk(1'b0, 1'b0, 1'b1, 1'b0, te, llc);
   endfunction
   function automatic logic [12:0] v_run(input bit te, input int unsigned llc);
      return mk(1'b0, 1'b0, 1'b0, 1'b1, te, llc);
   endfunction
   function automatic logic [12:0] v_stdby(input bit te, input int unsigned llc);
      return mk(1'b0, 1'b1, 1'b1, 1'b0, te, llc);
   endfunction

   task automatic push(input int unsigned dcyc, input string tag, input logic [12:0] exp);
      sb_t e;
      e.cyc = cyc + dcyc;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   // Leaves the bench just after the last edge that samples reset high.
   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      push(0, "rst_vals", v_prst(1'b0, 0));
      reset = 1'b0;
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      reset     = 1'b1;
      extlock   = 1'b0;
      stdby_req = 1'b0;

      // Power-up lock, then standby round trip.
      do_reset();
      push(1, "a_prst1", v_prst(1'b0, 0));
      push(3, "a_prst3", v_prst(1'b0, 0));
      push(4, "a_wait", v_wait(1'b0, 0));
      tick(6);
      extlock = 1'b1;
      push(10, "a_stab_end", v_wait(1'b0, 0));
      push(11, "a_run", v_run(1'b0, 0));
      tick(11);
      stdby_req = 1'b1;
      push(1, "a_stdby", v_stdby(1'b0, 0));
      tick(2);
      extlock = 1'b0;
      push(5, "a_stdby_noloss", v_stdby(1'b0, 0));
      tick(5);
      stdby_req = 1'b0;
      push(1, "a_stdby_exit", v_prst(1'b0, 0));
      push(4, "a_exit_prst4", v_prst(1'b0, 0));
      push(5, "a_exit_wait", v_wait(1'b0, 0));
      tick(5);
      extlock = 1'b1;
      push(10, "a_relock_stab", v_wait(1'b0, 0));
      push(11, "a_relock_run", v_run(1'b0, 0));
      tick(11);

      // Lock timeouts repeat every 24 cycles; timeout_err sticks through a later lock.
      extlock = 1'b0;
      do_reset();
      push(3, "b_prst", v_prst(1'b0, 0));
      push(4, "b_wait", v_wait(1'b0, 0));
      push(23, "b_wait_last", v_wait(1'b0, 0));
      push(24, "b_tmo1", v_prst(1'b1, 0));
      push(27, "b_tmo1_prst4", v_prst(1'b1, 0));
      push(28, "b_wait2", v_wait(1'b1, 0));
      push(47, "b_wait2_last", v_wait(1'b1, 0));
      push(48, "b_tmo2", v_prst(1'b1, 0));
      push(52, "b_wait3", v_wait(1'b1, 0));
      tick(54);
      extlock = 1'b1;
      push(10, "b_stab_end", v_wait(1'b1, 0));
      push(11, "b_run_te", v_run(1'b1, 0));
      tick(11);

      // One-cycle lock glitch during STAB restarts the stability window.
      extlock = 1'b0;
      do_reset();
      tick(4);
      extlock = 1'b1;
      tick(6);
      extlock = 1'b0;
      tick(1);
      extlock = 1'b1;
      push(4, "c_glitch_norun", v_wait(1'b0, 0));
      push(10, "c_glitch_stab", v_wait(1'b0, 0));
      push(11, "c_glitch_run", v_run(1'b0, 0));
      tick(11);

      // Repeated lock loss in RUN; counter saturates at 255.
      for (int i = 0; i < 300; i++) begin
         int unsigned nn;
         nn = (i + 1 > 255) ? 255 : i + 1;
         push(2, "c_loss_pre", v_run(1'b0, (i > 255) ? 255 : i));
         push(3, "c_loss_prst", v_prst(1'b0, nn));
         extlock = 1'b0;
         tick(1);
         extlock = 1'b1;
         push(15, "c_loss_relock", v_run(1'b0, nn));
         tick(15);
      end

      // Reset while in STDBY.
      stdby_req = 1'b1;
      push(1, "c_stdby_sat", v_stdby(1'b0, 255));
      tick(1);
      reset     = 1'b1;
      stdby_req = 1'b0;
      push(1, "c_rst_stdby", v_prst(1'b0, 0));
      tick(1);
      reset = 1'b0;
      push(3, "c_rst_prst4", v_prst(1'b0, 0));
      push(4, "c_rst_wait", v_wait(1'b0, 0));
      tick(4);

      // Reset while in STAB, then full restart with lock already present.
      extlock = 1'b0;
      do_reset();
      tick(4);
      extlock = 1'b1;
      tick(6);
      reset = 1'b1;
      push(1, "d_rst_stab", v_prst(1'b0, 0));
      tick(1);
      reset = 1'b0;
      push(3, "d_prst4", v_prst(1'b0, 0));
      push(4, "d_wait", v_wait(1'b0, 0));
      push(12, "d_stab_end", v_wait(1'b0, 0));
      push(13, "d_run", v_run(1'b0, 0));
      tick(13);

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick(1);
      check("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
